// File: rtl/mill_modif_demod.sv
// Modified Miller decoder for the ISO/IEC 14443 Type A reader-to-card link at 106 kbit/s.
// It turns pause starts on the RF envelope into an NRZ bit stream that is delayed by one ETU.
// That extra ETU lets the end-of-frame pattern be dropped before it reaches out_data.
// Configuration macro: PAUSE_INPUT_EN.
//   Defined:   the pause indicator comes from the `pause` input.
//   Undefined: the pause indicator is ~in_data.
module mill_modif_demod #(
    parameter int ETU_CLKS = 32,
    parameter int Z_LATE   = 4,
    parameter int Z_EARLY  = 28,
    parameter int X_LO     = 12,
    parameter int X_HI     = 20
) (
    input  logic clk,
    input  logic in_enable,
    input  logic in_data,
    output logic out_data,
    input  logic pause,
    input  logic rst_n
);
    localparam int CW = $clog2(ETU_CLKS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(ETU_CLKS - 1);
    localparam logic [CW-1:0] CNT_ZLATE = CW'(Z_LATE);
    localparam logic [CW-1:0] CNT_ZERLY = CW'(Z_EARLY);
    localparam logic [CW-1:0] CNT_XLO   = CW'(X_LO);
    localparam logic [CW-1:0] CNT_XHI   = CW'(X_HI);

    typedef enum logic [1:0] {ST_IDLE, ST_SOF, ST_RX} state_t;
    // Pause pattern recorded for the ETU currently in progress.
    typedef enum logic [1:0] {SYM_Y, SYM_X, SYM_Z} sym_t;

    state_t        state;
    sym_t          rec;
    logic [CW-1:0] cnt;
    logic          p_r, p_d;
    logic          prev, pend, pend_vld;
    logic          p_src, start, win_z, win_early, win_x, viol, close, eof, cls_bit;

`ifdef PAUSE_INPUT_EN
    logic unused_in_data;
    assign unused_in_data = in_data;
    assign p_src = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign p_src = ~in_data;
`endif

    assign start     = p_r & ~p_d;
    assign win_z     = (cnt <= CNT_ZLATE);
    assign win_early = (cnt >= CNT_ZERLY);
    assign win_x     = (cnt >= CNT_XLO) && (cnt <= CNT_XHI);
    // A start in the Z or X window is legal only if it is the first start of this ETU.
    // An early-Z start belongs to the next ETU, so it is always allowed.
    assign viol      = start && !win_early && !((win_z || win_x) && (rec == SYM_Y));
    assign close     = (cnt == CNT_LAST) || (start && win_early);
    assign eof       = (rec == SYM_Y) && !prev;
    assign cls_bit   = (rec == SYM_X);

    // Input flop, edge history, ETU counter, frame FSM and one-ETU output pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rec      <= SYM_Y;
            cnt      <= '0;
            p_r      <= 1'b0;
            p_d      <= 1'b0;
            prev     <= 1'b0;
            pend     <= 1'b0;
            pend_vld <= 1'b0;
            out_data <= 1'b0;
        end else if (!in_enable) begin
            state    <= ST_IDLE;
            rec      <= SYM_Y;
            cnt      <= '0;
            p_r      <= 1'b0;
            p_d      <= 1'b0;
            prev     <= 1'b0;
            pend     <= 1'b0;
            pend_vld <= 1'b0;
            out_data <= 1'b0;
        end else begin
            p_r <= p_src;
            p_d <= p_r;
            if (state == ST_IDLE) begin
                cnt <= '0;
                if (start) begin
                    // SOF: the Z pause opens ETU 0 of the frame.
                    state <= ST_SOF;
                    cnt   <= CW'(1);
                    rec   <= SYM_Z;
                    prev  <= 1'b0;
                end
            end else if (viol) begin
                state    <= ST_IDLE;
                rec      <= SYM_Y;
                cnt      <= '0;
                prev     <= 1'b0;
                pend     <= 1'b0;
                pend_vld <= 1'b0;
                out_data <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
                if (start && win_z) begin
                    cnt <= CW'(1);
                    rec <= SYM_Z;
                end
                if (start && win_x)
                    rec <= SYM_X;
                if (close) begin
                    rec <= start ? SYM_Z : SYM_Y;
                    if (start)
                        cnt <= CW'(1);
                    if (state == ST_SOF) begin
                        // The SOF ETU yields no bit.
                        state <= ST_RX;
                        prev  <= 1'b0;
                    end else if (eof) begin
                        // Y after a 0 ends the frame; the pending 0 belongs to the EOF pattern.
                        state    <= ST_IDLE;
                        rec      <= SYM_Y;
                        cnt      <= '0;
                        prev     <= 1'b0;
                        pend     <= 1'b0;
                        pend_vld <= 1'b0;
                        out_data <= 1'b0;
                    end else begin
                        out_data <= pend_vld & pend;
                        pend     <= cls_bit;
                        pend_vld <= 1'b1;
                        prev     <= cls_bit;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mill_modif_demod.sv
// Randomized bench for mill_modif_demod.
// Frames are encoded from bit lists into a per-cycle pause waveform.
// The expected out_data waveform is derived from ETU start times and the decode rules.
module tb_mill_modif_demod;
    localparam int MAXC = 12000;
    localparam int PLEN = 6;
    localparam int SY = 0, SX = 1, SZ = 2;

    logic clk = 1'b0, rst_n = 1'b0, in_enable = 1'b0, in_data = 1'b1, pause = 1'b0;
    logic out_data;
    int   n_chk = 0, n_err = 0, cyc;
    bit   pz [0:MAXC-1];
    bit   ex [0:MAXC-1];

    mill_modif_demod dut (
        .clk(clk), .in_enable(in_enable), .in_data(in_data),
        .out_data(out_data), .pause(pause), .rst_n(rst_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: out_data=%b expected %b", tag, cyc, act, exp);
        end
    endtask

    // Drive only the active pause source; the ignored one gets junk.
    task automatic drive(input bit p);
`ifdef PAUSE_INPUT_EN
        pause   = p;
        in_data = 1'($urandom);
`else
        in_data = ~p;
        pause   = 1'($urandom);
`endif
    endtask

    task automatic add_pause(input int c);
        for (int i = 0; i < PLEN; i++)
            if (c + i < MAXC) pz[c+i] = 1'b1;
    endtask

    // s: stim cycle of the SOF pause. dmode: 0 nominal, 1 random drift, 2 extreme (X 12/20, Z at -2).
    // vk: ETU index that receives a violating pause at offset 9 (0 means none).
    task automatic build_frame(input int s, input int nb, input logic [7:0] pat,
                               input int dmode, input int vk, output int fend);
        int pos_q[$];
        bit val_q[$];
        bit dec [0:9];
        int sym [0:9];
        bit prv = 1'b0;
        bit done = 1'b0;
        int m, start, nst, d, cls, nxt;
        m = nb + 2;
        for (int k = 1; k <= nb; k++) begin
            dec[k] = pat[k-1];
            sym[k] = dec[k] ? SX : (prv ? SY : SZ);
            prv    = dec[k];
        end
        dec[nb+1] = 1'b0; sym[nb+1] = SZ; sym[nb+2] = SY;
        add_pause(s);
        start = s + 1;
        fend  = 0;
        for (int k = 1; k <= m && !done; k++) begin
            nst = start + 32;
            if (k == vk) begin
                if (k - 1 >= 2) begin pos_q.push_back(nst - 1); val_q.push_back(dec[k-2]); end
                add_pause(nst + 8);
                pos_q.push_back(nst + 9); val_q.push_back(1'b0);
                fend = nst + 8 + PLEN;
                done = 1'b1;
            end else begin
                d = 0;
                if (sym[k] == SZ)
                    d = (dmode == 1) ? int'($urandom_range(8, 0)) - 4 : (dmode == 2) ? -2 : 0;
                cls = (d < 0) ? nst + d : nst - 1;
                if (k - 1 >= 2) begin pos_q.push_back(cls); val_q.push_back(dec[k-2]); end
                start = nst + d;
                if (sym[k] == SZ)
                    add_pause(start - 1);
                else if (sym[k] == SX)
                    add_pause(start - 1 + ((dmode == 1) ? int'($urandom_range(20, 12)) :
                                           (dmode == 2) ? ((k % 2 == 1) ? 12 : 20) : 16));
            end
        end
        if (!done) begin
            pos_q.push_back(start + 31); val_q.push_back(1'b0);
            fend = start + 32;
        end
        for (int i = 0; i < pos_q.size(); i++) begin
            nxt = (i + 1 < pos_q.size()) ? pos_q[i+1] : pos_q[i] + 1;
            for (int c = pos_q[i]; c < nxt && c < MAXC; c++) ex[c] = val_q[i];
        end
    endtask

    task automatic run_to(input int last, input string tag);
        while (cyc < last && cyc + 1 < MAXC - 1) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            chk(tag, out_data, ex[cyc]);
            drive(pz[cyc+1]);
        end
    endtask

    initial begin
        int fend, s, nb;
        cyc = -1;
        drive(1'b0);
        run_to(6, "reset");
        rst_n = 1'b1; in_enable = 1'b1;

        build_frame(cyc + 4, 3, 8'b101, 0, 0, fend);
        run_to(fend + 8, "frame_101");

        // Async reset while a 1 is on out_data, then a disabled period with toggling inputs.
        s = cyc + 4;
        build_frame(s, 3, 8'b111, 0, 0, fend);
        run_to(s + 112, "frame_111");
        chk("pre_rst_one", out_data, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", out_data, 1'b0);
        for (int c = cyc + 1; c < MAXC; c++) begin pz[c] = 1'b0; ex[c] = 1'b0; end
        in_enable = 1'b0;
        #1 rst_n = 1'b1;
        repeat (60) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            chk("disabled", out_data, 1'b0);
            in_data = 1'($urandom);
            pause   = 1'($urandom);
        end
        drive(1'b0);
        run_to(cyc + 3, "idle");
        in_enable = 1'b1;
        run_to(cyc + 5, "idle_en");

        build_frame(cyc + 4, 5, 8'b10110, 2, 0, fend);
        run_to(fend + 8, "drift");
        build_frame(cyc + 4, 2, 8'b00, 0, 0, fend);
        run_to(fend + 8, "frame_00");
        build_frame(cyc + 4, 4, 8'b1111, 0, 3, fend);
        run_to(fend, "violation");
        build_frame(cyc + 4, 3, 8'b101, 0, 0, fend);
        run_to(fend + 8, "after_viol");

        repeat (12) begin
            nb = int'($urandom_range(7, 1));
            build_frame(cyc + int'($urandom_range(20, 4)), nb, 8'($urandom), 1,
                        ($urandom_range(3, 0) == 0) ? int'($urandom_range(nb + 1, 2)) : 0, fend);
            run_to(fend + 6, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
